// File: rtl/floo_axis_vc_credit_scheduler.sv
// floo_axis_vc_credit_scheduler: round-robin, credit-gated mux of NoC VCs onto one registered AXIS link
module floo_axis_vc_credit_scheduler #(
    parameter int unsigned NumVc      = 2,
    parameter int unsigned DataWidth  = 64,
    parameter int unsigned NumCredits = 3,
    localparam int unsigned IdxW      = $clog2(NumVc),
    localparam int unsigned CntW      = $clog2(NumCredits + 1)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NumVc-1:0]          vc_valid_i,
    output logic [NumVc-1:0]          vc_ready_o,
    input  logic [NumVc*DataWidth-1:0] vc_data_i,
    output logic                      axis_tvalid_o,
    input  logic                      axis_tready_i,
    output logic [IdxW+DataWidth-1:0] axis_tdata_o,
    input  logic [NumVc-1:0]          credit_rtn_i,
    output logic [NumVc*CntW-1:0]     credits_o,
    output logic                      credit_err_o
);
    localparam logic [IdxW:0]   VcN    = (IdxW + 1)'(NumVc);
    localparam logic [IdxW-1:0] LastVc = IdxW'(NumVc - 1);
    localparam logic [CntW-1:0] MaxCnt = CntW'(NumCredits);

    logic [DataWidth-1:0] vc_data [NumVc];
    logic [CntW-1:0]      cnt_q   [NumVc];
    logic [CntW-1:0]      cnt_d   [NumVc];
    logic [NumVc-1:0]     elig;
    logic [IdxW-1:0]      ptr_q, gnt_idx, idx;
    logic [IdxW:0]        sum;
    logic                 gnt_found, load, gnt, err_d;

    for (genvar v = 0; v < NumVc; v++) begin : g_vc
        assign vc_data[v] = vc_data_i[v*DataWidth +: DataWidth];
        assign elig[v] = vc_valid_i[v] & (cnt_q[v] != '0);
        assign credits_o[v*CntW +: CntW] = cnt_q[v];
    end

    assign load = !axis_tvalid_o | axis_tready_i;
    assign gnt  = load & gnt_found;

    // First eligible VC at or after the round-robin pointer, wrapping around
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        sum       = '0;
        idx       = '0;
        for (int unsigned i = 0; i < NumVc; i++) begin
            sum = {1'b0, ptr_q} + (IdxW + 1)'(i);
            idx = IdxW'(sum >= VcN ? sum - VcN : sum);
            if (!gnt_found && elig[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = idx;
            end
        end
    end

    // One-hot accept strobe for the granted VC, forced low while in reset
    always_comb begin
        vc_ready_o = '0;
        if (rst_ni && gnt) vc_ready_o[gnt_idx] = 1'b1;
    end

    // Credit bookkeeping: a send consumes, a return refunds, both together cancel
    always_comb begin
        err_d = credit_err_o;
        for (int unsigned j = 0; j < NumVc; j++) begin
            cnt_d[j] = (vc_ready_o[j] && !credit_rtn_i[j]) ? cnt_q[j] - 1'b1 :
                       (credit_rtn_i[j] && !vc_ready_o[j] && cnt_q[j] != MaxCnt) ? cnt_q[j] + 1'b1 :
                       cnt_q[j];
            err_d = err_d | (credit_rtn_i[j] & !vc_ready_o[j] & (cnt_q[j] == MaxCnt));
        end
    end

    // Output register, RR pointer, credit counters and sticky overflow flag
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            axis_tvalid_o <= 1'b0;
            axis_tdata_o  <= '0;
            ptr_q         <= '0;
            credit_err_o  <= 1'b0;
            cnt_q         <= '{default: MaxCnt};
        end else begin
            credit_err_o <= err_d;
            cnt_q        <= cnt_d;
            if (load) begin
                axis_tvalid_o <= gnt_found;
                if (gnt_found) begin
                    axis_tdata_o <= {gnt_idx, vc_data[gnt_idx]};
                    ptr_q        <= (gnt_idx == LastVc) ? '0 : gnt_idx + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_floo_axis_vc_credit_scheduler.sv
// tb_floo_axis_vc_credit_scheduler: directed and random checks against a behavioural scheduler model
module tb_floo_axis_vc_credit_scheduler;
    localparam int NC = 3;

    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b1;
    logic [1:0]   vc_valid_i = '0;
    logic [1:0]   vc_ready_o;
    logic [127:0] vc_data_i = '0;
    logic         axis_tvalid_o;
    logic         axis_tready_i = 1'b0;
    logic [64:0]  axis_tdata_o;
    logic [1:0]   credit_rtn_i = '0;
    logic [3:0]   credits_o;
    logic         credit_err_o;

    int          total = 0, passed = 0, fails = 0;
    int          m_cnt [2];
    int          m_ptr, last_gnt, beats;
    bit          m_tv, m_err;
    logic [64:0] m_td;

    floo_axis_vc_credit_scheduler dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .vc_valid_i(vc_valid_i), .vc_ready_o(vc_ready_o),
        .vc_data_i(vc_data_i), .axis_tvalid_o(axis_tvalid_o), .axis_tready_i(axis_tready_i),
        .axis_tdata_o(axis_tdata_o), .credit_rtn_i(credit_rtn_i), .credits_o(credits_o),
        .credit_err_o(credit_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt[0] = NC; m_cnt[1] = NC;
        m_ptr = 0; m_tv = 0; m_err = 0; m_td = '0; last_gnt = -1;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        vc_valid_i = 2'b11; axis_tready_i = 1'b1; credit_rtn_i = '0; vc_data_i = '1;
        model_reset();
        @(posedge clk_i); #1;
        chk("rst_tvalid", axis_tvalid_o, 0);
        chk("rst_tdata", axis_tdata_o, 0);
        chk("rst_credits", credits_o, 4'hF);
        chk("rst_err", credit_err_o, 0);
        chk("rst_ready", vc_ready_o, 0);
        rst_ni = 1'b1;
    endtask

    // One clock of stimulus; the model predicts the grant and the next registered state
    task automatic cyc(input logic [1:0] v, input logic r, input logic [1:0] rt,
                       input logic [63:0] d0, input logic [63:0] d1);
        logic [63:0] d [2];
        logic [1:0]  er;
        int          g;
        bit          ld;
        vc_valid_i = v; axis_tready_i = r; credit_rtn_i = rt; vc_data_i = {d1, d0};
        d[0] = d0; d[1] = d1;
        #1;
        ld = !m_tv || r;
        g = -1;
        if (ld)
            for (int k = 0; k < 2; k++) begin
                int c = (m_ptr + k) % 2;
                if (g < 0 && v[c] && m_cnt[c] > 0) g = c;
            end
        er = (g >= 0) ? 2'(1 << g) : 2'b00;
        chk("vc_ready", vc_ready_o, er);
        if (ld) begin
            m_tv = (g >= 0);
            if (g >= 0) begin
                m_td = {1'(g), d[g]};
                m_ptr = (g + 1) % 2;
                beats++;
            end
        end
        for (int c = 0; c < 2; c++) begin
            if (g == c && !rt[c]) m_cnt[c]--;
            else if (rt[c] && g != c) begin
                if (m_cnt[c] == NC) m_err = 1;
                else m_cnt[c]++;
            end
        end
        last_gnt = g;
        @(posedge clk_i); #1;
        chk("tvalid", axis_tvalid_o, m_tv);
        if (m_tv) chk("tdata", axis_tdata_o, m_td);
        chk("credits", credits_o, {2'(m_cnt[1]), 2'(m_cnt[0])});
        chk("credit_err", credit_err_o, m_err);
    endtask

    initial begin
        int h1, h2;
        logic [1:0] rt;
        // Alternating grants with credits returned two cycles after each send
        do_reset();
        h1 = -1; h2 = -1;
        for (int i = 0; i < 10; i++) begin
            rt = (h2 >= 0) ? 2'(1 << h2) : 2'b00;
            cyc(2'b11, 1'b1, rt, 64'h100 + 64'(i), 64'h200 + 64'(i));
            chk("t1_alt", last_gnt, i % 2);
            chk("t1_tag", axis_tdata_o[64], i % 2);
            h2 = h1; h1 = last_gnt;
        end
        chk("t1_noerr", credit_err_o, 0);
        // Single VC drains its credits, then resumes after one return
        do_reset();
        beats = 0;
        for (int i = 0; i < 5; i++) cyc(2'b10, 1'b1, 2'b00, 64'h0, 64'h400 + 64'(i));
        chk("t2_beats", beats, 3);
        chk("t2_cred1", credits_o[3:2], 0);
        chk("t2_ready", vc_ready_o, 0);
        cyc(2'b10, 1'b1, 2'b10, 64'h0, 64'h4AA);
        chk("t2_wait", axis_tvalid_o, 0);
        cyc(2'b10, 1'b1, 2'b00, 64'h0, 64'h4BB);
        chk("t2_4th", axis_tvalid_o, 1);
        chk("t2_4th_data", axis_tdata_o, {1'b1, 64'h4BB});
        // Starved VC0 does not block VC1
        do_reset();
        for (int i = 0; i < 3; i++) cyc(2'b01, 1'b1, 2'b00, 64'h11, 64'h0);
        for (int i = 0; i < 6; i++) begin
            cyc(2'b11, 1'b1, 2'b10, 64'hA5, 64'h300 + 64'(i));
            chk("t3_vc1", last_gnt, 1);
            chk("t3_no_a5", axis_tdata_o, {1'b1, 64'h300 + 64'(i)});
        end
        cyc(2'b11, 1'b1, 2'b01, 64'hA5, 64'h3FF);
        chk("t3_vc1_again", last_gnt, 1);
        cyc(2'b11, 1'b1, 2'b00, 64'hA5, 64'h3FE);
        chk("t3_a5", axis_tdata_o, {1'b0, 64'hA5});
        // Backpressure holds the beat, then consume and regrant in one cycle
        do_reset();
        cyc(2'b11, 1'b1, 2'b00, 64'hC0, 64'hC1);
        for (int i = 0; i < 5; i++) begin
            cyc(2'b11, 1'b0, 2'b00, 64'hD0 + 64'(i), 64'hE0 + 64'(i));
            chk("t4_hold", axis_tdata_o, {1'b0, 64'hC0});
            chk("t4_cred", credits_o, 4'b1110);
        end
        cyc(2'b11, 1'b1, 2'b00, 64'hF0, 64'hF1);
        chk("t4_regrant", last_gnt, 1);
        chk("t4_next", axis_tdata_o, {1'b1, 64'hF1});
        // Simultaneous grant and return, then overflow sets the sticky flag
        do_reset();
        cyc(2'b01, 1'b1, 2'b00, 64'h51, 64'h0);
        cyc(2'b01, 1'b1, 2'b01, 64'h52, 64'h0);
        chk("t5_both", credits_o[1:0], 2);
        cyc(2'b00, 1'b1, 2'b01, 64'h0, 64'h0);
        chk("t5_noerr", credit_err_o, 0);
        cyc(2'b00, 1'b1, 2'b01, 64'h0, 64'h0);
        chk("t5_err", credit_err_o, 1);
        chk("t5_sat", credits_o[1:0], 3);
        cyc(2'b00, 1'b1, 2'b00, 64'h0, 64'h0);
        chk("t5_sticky", credit_err_o, 1);
        // Asynchronous reset mid-stream
        do_reset();
        cyc(2'b11, 1'b1, 2'b00, 64'h61, 64'h62);
        cyc(2'b11, 1'b1, 2'b00, 64'h63, 64'h64);
        chk("t6_tv", axis_tvalid_o, 1);
        rst_ni = 1'b0;
        #1;
        chk("t6_tvalid", axis_tvalid_o, 0);
        chk("t6_tdata", axis_tdata_o, 0);
        chk("t6_credits", credits_o, 4'hF);
        chk("t6_ready", vc_ready_o, 0);
        do_reset();
        cyc(2'b11, 1'b1, 2'b00, 64'h71, 64'h72);
        chk("t6_first", last_gnt, 0);
        // Random traffic, backpressure and credit returns
        do_reset();
        for (int i = 0; i < 400; i++) begin
            for (int c = 0; c < 2; c++)
                rt[c] = (m_cnt[c] < NC) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 63) == 0);
            cyc(2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0), rt,
                {$urandom, $urandom}, {$urandom, $urandom});
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
